// File: rtl/generic_dpram_init.sv
// ---------------------------------------------------------------------------
// generic_dpram_init
//
// Single-clock simple dual-port RAM (one write port, one read port) used for
// IMSIC storage arrays. Adds per-lane write enables, a 1- or 2-cycle read
// latency, selectable read-during-write behaviour, a read-valid strobe and a
// hardware clear engine that fills the array with InitValue.
//
// Ports
//   clk       single clock, all state changes on posedge
//   rstn      asynchronous active-low reset (array contents are kept)
//   init_req  one-cycle pulse, starts a clear sweep when busy=0
//   busy      high while the clear sweep runs; we/re are ignored then
//   we        write enable
//   waddr     write address
//   wbe       lane write enables, bit i covers wd[i*LaneBits +: LaneBits]
//   wd        write data
//   re        read enable
//   raddr     read address
//   rd        read data, holds its value between reads
//   rvalid    one-cycle strobe marking rd as valid
// ---------------------------------------------------------------------------
module generic_dpram_init #(
  parameter int unsigned        NumWords    = 32,
  parameter int unsigned        AddrBits    = 5,
  parameter int unsigned        NumBits     = 32,
  parameter int unsigned        LaneBits    = 8,
  parameter int unsigned        OutReg      = 0,
  parameter int unsigned        Bypass      = 1,
  parameter int unsigned        InitOnReset = 1,
  parameter logic [NumBits-1:0] InitValue   = {NumBits{1'b0}},
  localparam int unsigned       NumLanes    = NumBits / LaneBits
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                init_req,
  output logic                busy,
  input  logic                we,
  input  logic [AddrBits-1:0] waddr,
  input  logic [NumLanes-1:0] wbe,
  input  logic [NumBits-1:0]  wd,
  input  logic                re,
  input  logic [AddrBits-1:0] raddr,
  output logic [NumBits-1:0]  rd,
  output logic                rvalid
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_INIT = 1'b1
  } state_e;

  // One extra bit so NumWords == 2**AddrBits still compares correctly.
  localparam logic [AddrBits:0]   NumWordsW  = (AddrBits + 1)'(NumWords);
  localparam logic [AddrBits-1:0] LastAddr   = AddrBits'(NumWords - 1);
  localparam state_e              ResetState = (InitOnReset != 0) ? ST_INIT : ST_IDLE;
  localparam logic                ResetBusy  = (InitOnReset != 0) ? 1'b1 : 1'b0;

  logic [NumBits-1:0]  mem_q [NumWords];

  state_e              state_q,    state_d;
  logic [AddrBits-1:0] cnt_q,      cnt_d;
  logic                busy_q,     busy_d;
  logic                s1_valid_q, s1_valid_d;
  logic [NumBits-1:0]  s1_data_q,  s1_data_d;
  logic                rvalid_q,   rvalid_d;
  logic [NumBits-1:0]  rd_q,       rd_d;

  logic                init_wr_s;
  logic                wr_en_s;
  logic                rd_en_s;
  logic                rd_hit_s;
  logic [NumBits-1:0]  rdata_s;

  // Qualify user accesses: nothing from the ports reaches the array while sweeping.
  always_comb begin
    init_wr_s = (state_q == ST_INIT);
    wr_en_s   = we & ~busy_q & ({1'b0, waddr} < NumWordsW);
    rd_en_s   = re & ~busy_q;
    rd_hit_s  = rd_en_s & ({1'b0, raddr} < NumWordsW);
  end

  // Read data for this cycle, with optional per-lane forwarding of a same-address write.
  always_comb begin
    rdata_s = {NumBits{1'b0}};
    if (rd_hit_s) begin
      rdata_s = mem_q[raddr];
      if ((Bypass != 0) && wr_en_s && (waddr == raddr)) begin
        for (int i = 0; i < NumLanes; i++) begin
          if (wbe[i]) begin
            rdata_s[i*LaneBits +: LaneBits] = wd[i*LaneBits +: LaneBits];
          end else begin
            rdata_s[i*LaneBits +: LaneBits] = mem_q[raddr][i*LaneBits +: LaneBits];
          end
        end
      end else begin
        rdata_s = mem_q[raddr];
      end
    end else begin
      rdata_s = {NumBits{1'b0}};
    end
  end

  // Clear-engine next state: sweep one word per cycle, then return to idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = {AddrBits{1'b0}};
        if (init_req) begin
          state_d = ST_INIT;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_INIT: begin
        // init_req is deliberately not looked at here: a sweep is never restarted.
        if (cnt_q == LastAddr) begin
          state_d = ST_IDLE;
          cnt_d   = {AddrBits{1'b0}};
          busy_d  = 1'b0;
        end else begin
          state_d = ST_INIT;
          cnt_d   = cnt_q + {{(AddrBits-1){1'b0}}, 1'b1};
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {AddrBits{1'b0}};
        busy_d  = 1'b0;
      end
    endcase
  end

  // Read pipeline next state; in-flight reads keep draining even once a sweep starts.
  always_comb begin
    s1_valid_d = rd_en_s;
    s1_data_d  = rd_en_s ? rdata_s : s1_data_q;
    if (OutReg != 0) begin
      rvalid_d = s1_valid_q;
      rd_d     = s1_valid_q ? s1_data_q : rd_q;
    end else begin
      rvalid_d = rd_en_s;
      rd_d     = rd_en_s ? rdata_s : rd_q;
    end
  end

  // Control and read-path registers; reset aborts any sweep and rearms it if configured.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ResetState;
      cnt_q      <= {AddrBits{1'b0}};
      busy_q     <= ResetBusy;
      s1_valid_q <= 1'b0;
      s1_data_q  <= {NumBits{1'b0}};
      rvalid_q   <= 1'b0;
      rd_q       <= {NumBits{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      rvalid_q   <= rvalid_d;
      rd_q       <= rd_d;
    end
  end

  // Storage array, not reset; the sweep has priority over the (already blocked) write port.
  always_ff @(posedge clk) begin
    if (init_wr_s) begin
      mem_q[cnt_q] <= InitValue;
    end else if (wr_en_s) begin
      for (int i = 0; i < NumLanes; i++) begin
        if (wbe[i]) begin
          mem_q[waddr][i*LaneBits +: LaneBits] <= wd[i*LaneBits +: LaneBits];
        end
      end
    end
  end

  assign busy   = busy_q;
  assign rd     = rd_q;
  assign rvalid = rvalid_q;

endmodule

// File: tb/tb_generic_dpram_init.sv
// ---------------------------------------------------------------------------
// tb_generic_dpram_init
//
// Two instances driven by the same stimulus:
//   dut_a : 32 words, read latency 1, bypass on, InitValue 0
//   dut_b : 20 words, read latency 2, bypass off, InitValue 32'h5A5AC3C3
// Each read issued while the RAMs are idle pushes a hand-computed expected
// word and due cycle per instance; per-instance monitors pop on rvalid.
// ---------------------------------------------------------------------------
module tb_generic_dpram_init;

  localparam logic [31:0] INIT_B = 32'h5A5AC3C3;

  typedef struct {
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic        init_req;
  logic        we;
  logic [4:0]  waddr;
  logic [3:0]  wbe;
  logic [31:0] wd;
  logic        re;
  logic [4:0]  raddr;

  logic        busy_a, busy_b;
  logic [31:0] rd_a, rd_b;
  logic        rvalid_a, rvalid_b;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea_m;
  exp_t eb_m;

  generic_dpram_init #(
    .NumWords(32), .AddrBits(5), .NumBits(32), .LaneBits(8),
    .OutReg(0), .Bypass(1), .InitOnReset(1), .InitValue(32'h00000000)
  ) dut_a (
    .clk(clk), .rstn(rstn), .init_req(init_req), .busy(busy_a),
    .we(we), .waddr(waddr), .wbe(wbe), .wd(wd),
    .re(re), .raddr(raddr), .rd(rd_a), .rvalid(rvalid_a)
  );

  generic_dpram_init #(
    .NumWords(20), .AddrBits(5), .NumBits(32), .LaneBits(8),
    .OutReg(1), .Bypass(0), .InitOnReset(1), .InitValue(INIT_B)
  ) dut_b (
    .clk(clk), .rstn(rstn), .init_req(init_req), .busy(busy_b),
    .we(we), .waddr(waddr), .wbe(wbe), .wd(wd),
    .re(re), .raddr(raddr), .rd(rd_b), .rvalid(rvalid_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor for dut_a: every rvalid must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rvalid_a) begin
      if (qa.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_rvalid actual=%h required=no_rvalid", rd_a);
      end else begin
        ea_m = qa.pop_front();
        check("a_rd", rd_a, ea_m.data);
        check("a_latency_cycle", cyc, ea_m.due);
      end
    end
  end

  // Monitor for dut_b.
  always @(negedge clk) begin
    if (rvalid_b) begin
      if (qb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected_rvalid actual=%h required=no_rvalid", rd_b);
      end else begin
        eb_m = qb.pop_front();
        check("b_rd", rd_b, eb_m.data);
        check("b_latency_cycle", cyc, eb_m.due);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One cycle of port activity; a read pushes expectations (A latency 1, B latency 2).
  task automatic access(input bit w, input logic [4:0] wa, input logic [3:0] be,
                        input logic [31:0] d, input bit r, input logic [4:0] ra,
                        input logic [31:0] exp_a, input logic [31:0] exp_b, input bit ireq);
    we = w; waddr = wa; wbe = be; wd = d;
    re = r; raddr = ra; init_req = ireq;
    if (r) begin
      qa.push_back('{exp_a, cyc + 1});
      qb.push_back('{exp_b, cyc + 2});
    end
    cycle();
    we = 1'b0; re = 1'b0; init_req = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
    access(1'b1, a, be, d, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic rdx(input logic [4:0] a, input logic [31:0] exp_a, input logic [31:0] exp_b);
    access(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, a, exp_a, exp_b, 1'b0);
  endtask

  // Count busy cycles of both instances; optionally inject ignored traffic mid-sweep.
  task automatic sweep(input bit traffic, input string tag);
    int unsigned na;
    int unsigned nb;
    na = 0;
    nb = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy_a) na++;
      if (busy_b) nb++;
      if (!busy_a && !busy_b) break;
      if (traffic) begin
        we = (i == 12); waddr = 5'd2; wbe = 4'hF; wd = 32'h00000099;
        re = (i == 12); raddr = 5'd2;
        init_req = (i == 5);
      end
      cycle();
      we = 1'b0; re = 1'b0; init_req = 1'b0;
    end
    check({tag, "_busy_cycles_a"}, na, 32'd32);
    check({tag, "_busy_cycles_b"}, nb, 32'd20);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b1; init_req = 1'b0; we = 1'b0; waddr = 5'd0; wbe = 4'h0;
    wd = 32'h0; re = 1'b0; raddr = 5'd0;
    #3 rstn = 1'b0;
    #1;
    check("rst_rd_a", rd_a, 32'h0);
    check("rst_rvalid_a", {31'd0, rvalid_a}, 32'd0);
    check("rst_busy_a", {31'd0, busy_a}, 32'd1);
    check("rst_rd_b", rd_b, 32'h0);
    check("rst_busy_b", {31'd0, busy_b}, 32'd1);
    cycle();
    rstn = 1'b1;
    sweep(1'b0, "por");

    // Post-sweep contents, back-to-back reads; B beyond 19 is out of range.
    for (int i = 0; i < 32; i++) begin
      rdx(5'(i), 32'h00000000, (i < 20) ? INIT_B : 32'h00000000);
    end

    // Lane enables.
    wr(5'd5, 4'b1111, 32'hAABBCCDD);
    wr(5'd5, 4'b0101, 32'h11223344);
    rdx(5'd5, 32'hAA22CC44, 32'hAA22CC44);

    // Read-during-write on addr 3, lanes 0/1.
    access(1'b1, 5'd3, 4'b0011, 32'hDEADBEEF, 1'b1, 5'd3, 32'h0000BEEF, INIT_B, 1'b0);
    rdx(5'd3, 32'h0000BEEF, 32'h5A5ABEEF);

    // wbe=0 is a no-op; addr 25 is in range only for A.
    wr(5'd5, 4'b0000, 32'hFFFFFFFF);
    rdx(5'd5, 32'hAA22CC44, 32'hAA22CC44);
    wr(5'd25, 4'b1111, 32'h12345678);
    rdx(5'd25, 32'h12345678, 32'h00000000);

    // Sweep on request with a read in the same cycle, plus dropped traffic mid-sweep.
    wr(5'd7, 4'b1111, 32'h00000005);
    access(1'b0, 5'd0, 4'h0, 32'h0, 1'b1, 5'd7, 32'h00000005, 32'h00000005, 1'b1);
    sweep(1'b1, "req");
    rdx(5'd7, 32'h00000000, INIT_B);
    rdx(5'd2, 32'h00000000, INIT_B);
    rdx(5'd25, 32'h00000000, 32'h00000000);

    // Reset at sweep cycle 10.
    wr(5'd9, 4'b1111, 32'hCAFEF00D);
    rdx(5'd9, 32'hCAFEF00D, 32'hCAFEF00D);
    repeat (3) cycle();
    access(1'b0, 5'd0, 4'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
    repeat (10) cycle();
    rstn = 1'b0;
    #1;
    check("mid_rd_a", rd_a, 32'h0);
    check("mid_rvalid_a", {31'd0, rvalid_a}, 32'd0);
    check("mid_rd_b", rd_b, 32'h0);
    check("mid_rvalid_b", {31'd0, rvalid_b}, 32'd0);
    cycle();
    rstn = 1'b1;
    sweep(1'b0, "mid");
    rdx(5'd9, 32'h00000000, INIT_B);
    rdx(5'd25, 32'h00000000, 32'h00000000);

    repeat (5) cycle();
    check("a_outstanding_reads", 32'(qa.size()), 32'd0);
    check("b_outstanding_reads", 32'(qb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
